// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for 10-bit DAC samples: {CMD, data, 2'b00} shifted MSB-first,
// followed by a chip-select hold phase and an inter-frame gap.
module dac_spi_tx #(
  parameter int          DATA_W  = 10,
  parameter int          CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              sclk_out,
  output logic              mosi_out,
  output logic              cs_n_out,
  output logic              done_out
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shreg;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ready_out <= 1'b0;
      sclk_out  <= 1'b0;
      mosi_out  <= 1'b0;
      cs_n_out  <= 1'b1;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          cs_n_out  <= 1'b1;
          sclk_out  <= 1'b0;
          mosi_out  <= 1'b0;
          div_cnt   <= '0;
          if (valid_in && ready_out) begin
            state     <= SHIFT;
            shreg     <= {CMD, data_in, 2'b00};
            bit_cnt   <= 4'd15;
            ready_out <= 1'b0;
            cs_n_out  <= 1'b0;
            mosi_out  <= CMD[3];
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            if (!sclk_out) begin
              sclk_out <= 1'b1;
            end else begin
              // Falling edge: the only point where mosi may move to the next bit.
              sclk_out <= 1'b0;
              if (bit_cnt == 4'd0) begin
                state    <= HOLD;
                mosi_out <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt - 4'd1;
                shreg    <= {shreg[14:0], 1'b0};
                mosi_out <= shreg[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_wrap) begin
            div_cnt  <= '0;
            state    <= GAP;
            cs_n_out <= 1'b1;
            done_out <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (div_wrap) begin
            div_cnt   <= '0;
            state     <= IDLE;
            ready_out <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default divider instance plus a CLK_DIV=1 instance.
module tb_dac_spi_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, valid0, rdy0, sclk0, mosi0, csn0, done0;
  logic       rst1, valid1, rdy1, sclk1, mosi1, csn1, done1;
  logic [9:0] data0, data1;

  dac_spi_tx u0 (
    .clk_in(clk), .rst_in(rst0), .data_in(data0), .valid_in(valid0), .ready_out(rdy0),
    .sclk_out(sclk0), .mosi_out(mosi0), .cs_n_out(csn0), .done_out(done0));

  dac_spi_tx #(.CLK_DIV(1)) u1 (
    .clk_in(clk), .rst_in(rst1), .data_in(data1), .valid_in(valid1), .ready_out(rdy1),
    .sclk_out(sclk1), .mosi_out(mosi1), .cs_n_out(csn1), .done_out(done1));

  int ncmp = 0;
  int nerr = 0;

  logic [15:0] cap;
  int rises, cs_bad, sclk_bad, mosi_bad, done_cnt, done_at, rdy_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes cycles 1..ncyc after an accepting edge (cycle c sampled at the negedge after edge c-1).
  task automatic watch(input bit sel, input int d, input int ncyc, input bit keep_valid,
                       input logic [9:0] nxt_data, input int pulse_at);
    logic s, m, cs, dn, rd, ps, pm, exp_cs, exp_s;
    ps = 1'b0; pm = 1'b0; cap = '0;
    rises = 0; cs_bad = 0; sclk_bad = 0; mosi_bad = 0; done_cnt = 0; done_at = 0; rdy_at = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (sel) begin data1 = nxt_data; if (!keep_valid) valid1 = 1'b0; end
        else     begin data0 = nxt_data; if (!keep_valid) valid0 = 1'b0; end
      end
      if (!sel && pulse_at != 0 && c == pulse_at)     begin valid0 = 1'b1; data0 = 10'h155; end
      if (!sel && pulse_at != 0 && c == pulse_at + 1) valid0 = 1'b0;
      s  = sel ? sclk1 : sclk0;
      m  = sel ? mosi1 : mosi0;
      cs = sel ? csn1  : csn0;
      dn = sel ? done1 : done0;
      rd = sel ? rdy1  : rdy0;
      if (s === 1'b1 && ps === 1'b0) begin cap = {cap[14:0], m}; rises++; end
      exp_cs = !(c <= 33 * d);
      if (cs !== exp_cs) cs_bad++;
      exp_s = (c <= 32 * d) ? ((((c - 1) / d) % 2) == 1) : 1'b0;
      if (s !== exp_s) sclk_bad++;
      if (c >= 2 && c <= 33 * d && m !== pm && !(ps === 1'b1 && s === 1'b0)) mosi_bad++;
      if (dn !== 1'b0) begin done_cnt++; if (done_at == 0) done_at = c; end
      if (rd === 1'b1 && rdy_at == 0) rdy_at = c;
      ps = s; pm = m;
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs0", {27'd0, rdy0, sclk0, mosi0, csn0, done0}, 32'b00010);
      chk("rst_outs1", {27'd0, rdy1, sclk1, mosi1, csn1, done1}, 32'b00010);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rel_outs0", {27'd0, rdy0, sclk0, mosi0, csn0, done0}, 32'b10010);
    chk("rel_rdy1", {31'd0, rdy1}, 32'd1);

    // Single frame 0x2A5
    data0 = 10'h2A5; valid0 = 1'b1;
    watch(1'b0, 4, 140, 1'b0, 10'h0F0, 0);
    chk("single/cap", {16'd0, cap}, 32'h3A94);
    chk("single/rises", rises, 16);
    chk("single/cs", cs_bad, 0);
    chk("single/sclk", sclk_bad, 0);
    chk("single/mosi", mosi_bad, 0);
    chk("single/done_cnt", done_cnt, 1);
    chk("single/done_at", done_at, 133);
    chk("single/rdy_at", rdy_at, 137);

    // Back-to-back 0x3FF then 0x000 with valid held high
    data0 = 10'h3FF; valid0 = 1'b1;
    watch(1'b0, 4, 137, 1'b1, 10'h000, 0);
    chk("b2b1/cap", {16'd0, cap}, 32'h3FFC);
    chk("b2b1/cs", cs_bad, 0);
    chk("b2b1/done_at", done_at, 133);
    chk("b2b1/rdy_at", rdy_at, 137);
    watch(1'b0, 4, 140, 1'b0, 10'h000, 0);
    chk("b2b2/cap", {16'd0, cap}, 32'h3000);
    chk("b2b2/rises", rises, 16);
    chk("b2b2/cs", cs_bad, 0);
    chk("b2b2/done_at", done_at, 133);

    // Valid pulse during SHIFT is ignored
    data0 = 10'h2A5; valid0 = 1'b1;
    watch(1'b0, 4, 140, 1'b0, 10'h2A5, 50);
    chk("ign/cap", {16'd0, cap}, 32'h3A94);
    chk("ign/rises", rises, 16);
    chk("ign/cs", cs_bad, 0);
    chk("ign/done_cnt", done_cnt, 1);
    chk("ign/rdy_at", rdy_at, 137);

    // Reset on cycle 40 of a frame
    data0 = 10'h2A5; valid0 = 1'b1;
    watch(1'b0, 4, 40, 1'b0, 10'h2A5, 0);
    chk("mrst/no_done", done_cnt, 0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("mrst/outs", {27'd0, rdy0, sclk0, mosi0, csn0, done0}, 32'b00010);
    rst0 = 1'b0;
    @(negedge clk);
    chk("mrst/rel", {27'd0, rdy0, sclk0, mosi0, csn0, done0}, 32'b10010);
    data0 = 10'h001; valid0 = 1'b1;
    watch(1'b0, 4, 140, 1'b0, 10'h001, 0);
    chk("mrst/cap", {16'd0, cap}, 32'h3004);
    chk("mrst/rises", rises, 16);
    chk("mrst/done_at", done_at, 133);
    chk("mrst/rdy_at", rdy_at, 137);

    // CLK_DIV=1 instance
    data1 = 10'h2A5; valid1 = 1'b1;
    watch(1'b1, 1, 38, 1'b0, 10'h2A5, 0);
    chk("div1/cap", {16'd0, cap}, 32'h3A94);
    chk("div1/rises", rises, 16);
    chk("div1/sclk", sclk_bad, 0);
    chk("div1/cs", cs_bad, 0);
    chk("div1/done_at", done_at, 34);
    chk("div1/done_cnt", done_cnt, 1);
    chk("div1/rdy_at", rdy_at, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
